// File: rtl/coletor_digitos_pkg.sv
// rtl/coletor_digitos_pkg.sv - shared types and constants for the keypad digit collector
package coletor_digitos_pkg;

  localparam int N_DIGITOS = 20;

  // Index [0] holds the most recently typed digit
  typedef logic [N_DIGITOS-1:0][3:0] senhaPac_t;

  // Live echo digits, BCD0 is the most recent
  typedef struct packed {
    logic [3:0] BCD5;
    logic [3:0] BCD4;
    logic [3:0] BCD3;
    logic [3:0] BCD2;
    logic [3:0] BCD1;
    logic [3:0] BCD0;
  } bcdPac_t;

  localparam logic [3:0] KEY_ESTRELA   = 4'hA;
  localparam logic [3:0] KEY_CERQUILHA = 4'hB;
  localparam logic [3:0] DIG_VAZIO     = 4'hF;

  localparam senhaPac_t SENHA_VAZIA = {N_DIGITOS{DIG_VAZIO}};
  localparam senhaPac_t SENHA_ESC   = {N_DIGITOS{4'hB}};
  localparam bcdPac_t   BCD_VAZIO   = {6{DIG_VAZIO}};

  typedef enum logic [1:0] {
    VAZIO  = 2'd0,
    COLETA = 2'd1,
    EMITE  = 2'd2
  } coletor_estado_t;

  // Keys 0x0-0x9 are digits; everything else is a command or ignored
  function automatic logic eh_digito(input logic [3:0] codigo);
    return (codigo <= 4'h9);
  endfunction

endpackage

// File: rtl/coletor_digitos_if.sv
// rtl/coletor_digitos_if.sv - key strobe input and packet/echo output bundle
interface coletor_digitos_if;
  import coletor_digitos_pkg::*;

  logic [3:0] key_code;
  logic       key_valid;
  senhaPac_t  digitos_value;
  logic       digitos_valid;
  logic       display_en;
  bcdPac_t    bcd_pac;

  // Keypad decoder side: drives keys, observes packets
  modport master (
    output key_code,
    output key_valid,
    input  digitos_value,
    input  digitos_valid,
    input  display_en,
    input  bcd_pac
  );

  // Collector side
  modport slave (
    input  key_code,
    input  key_valid,
    output digitos_value,
    output digitos_valid,
    output display_en,
    output bcd_pac
  );

endinterface

// File: rtl/coletor_digitos_contador_timeout.sv
// rtl/coletor_digitos_contador_timeout.sv - idle counter that flags an abandoned entry
module contador_timeout #(
  parameter int TIMEOUT_CYCLES = 5_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic clear,
  output logic expired
);

  localparam int W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [W-1:0] LIMITE = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] cont_q;

  // Expiry is seen in the same cycle the last idle count is reached, so the
  // collector can drop the buffer on that edge; an accepted key drops run
  assign expired = run && !clear && (cont_q == LIMITE);

  // Count idle cycles, restart on clear or after expiring
  always_ff @(posedge clk) begin
    if (!rst) begin
      cont_q <= '0;
    end else if (clear || expired) begin
      cont_q <= '0;
    end else if (run) begin
      cont_q <= cont_q + W'(1);
    end
  end

endmodule

// File: rtl/coletor_digitos.sv
// rtl/coletor_digitos.sv - collects keypad digits into a password packet with live echo
module coletor_digitos
  import coletor_digitos_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 5_000_000,
  parameter bit ECHO_EN        = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  coletor_digitos_if.slave bus
);

  coletor_estado_t estado_q, estado_d;
  senhaPac_t       buffer_q, buffer_d;
  senhaPac_t       valor_q, valor_d;
  logic            valid_q, valid_d;
  bcdPac_t         bcd_q, bcd_d;

  logic      tecla, digito, cerquilha, estrela, aceita;
  logic      em_coleta, run, clear, expirou;
  senhaPac_t deslocado;

  // Key classification; nothing counts while collection is disabled
  assign tecla     = bus.key_valid && enable;
  assign digito    = tecla && eh_digito(bus.key_code);
  assign cerquilha = tecla && (bus.key_code == KEY_CERQUILHA);
  assign estrela   = tecla && (bus.key_code == KEY_ESTRELA);
  assign aceita    = digito || cerquilha || estrela;
  assign em_coleta = (estado_q == COLETA);

  // Codes 0xC-0xF are not accepted, so they let the idle counter keep running
  assign run   = em_coleta && enable && !aceita;
  assign clear = !em_coleta || !enable || aceita;

  // Newest digit enters at [0]; the oldest at [19] falls off on overflow
  assign deslocado = {buffer_q[N_DIGITOS-2:0], bus.key_code};

  contador_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .run    (run),
    .clear  (clear),
    .expired(expirou)
  );

  // Next state of the collector; EMITE behaves like VAZIO for an incoming key
  always_comb begin
    estado_d = estado_q;
    buffer_d = buffer_q;
    valor_d  = valor_q;
    valid_d  = 1'b0;
    if (!enable) begin
      estado_d = VAZIO;
      buffer_d = SENHA_VAZIA;
    end else begin
      case (estado_q)
        COLETA: begin
          if (digito) begin
            buffer_d = deslocado;
          end else if (cerquilha) begin
            valor_d  = buffer_q;
            valid_d  = 1'b1;
            buffer_d = SENHA_VAZIA;
            estado_d = EMITE;
          end else if (estrela) begin
            buffer_d = SENHA_VAZIA;
            estado_d = VAZIO;
          end else if (expirou) begin
            buffer_d = SENHA_VAZIA;
            estado_d = VAZIO;
          end
        end
        default: begin
          estado_d = VAZIO;
          buffer_d = SENHA_VAZIA;
          if (digito) begin
            buffer_d = {SENHA_VAZIA[N_DIGITOS-2:0], bus.key_code};
            estado_d = COLETA;
          end else if (cerquilha) begin
            valor_d  = SENHA_VAZIA;
            valid_d  = 1'b1;
            estado_d = EMITE;
          end else if (estrela) begin
            valor_d  = SENHA_ESC;
            valid_d  = 1'b1;
            estado_d = EMITE;
          end
        end
      endcase
    end
  end

  // Echo digits follow the buffer; the buffer is all 0xF whenever not collecting
  always_comb begin
    bcd_d = BCD_VAZIO;
    if (ECHO_EN) begin
      bcd_d.BCD0 = buffer_d[0];
      bcd_d.BCD1 = buffer_d[1];
      bcd_d.BCD2 = buffer_d[2];
      bcd_d.BCD3 = buffer_d[3];
      bcd_d.BCD4 = buffer_d[4];
      bcd_d.BCD5 = buffer_d[5];
    end
  end

  // Collector state, buffer and registered outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      estado_q <= VAZIO;
      buffer_q <= SENHA_VAZIA;
      valor_q  <= SENHA_VAZIA;
      valid_q  <= 1'b0;
      bcd_q    <= BCD_VAZIO;
    end else begin
      estado_q <= estado_d;
      buffer_q <= buffer_d;
      valor_q  <= valor_d;
      valid_q  <= valid_d;
      bcd_q    <= bcd_d;
    end
  end

  assign bus.digitos_value = valor_q;
  assign bus.digitos_valid = valid_q;
  assign bus.display_en    = ECHO_EN && enable && em_coleta;
  assign bus.bcd_pac       = bcd_q;

endmodule
